imm_gen_pipe: RTL and testbench

- Parametrised, pipelined immediate generator for the decode stage.
- Accepts one 32-bit RISC-V instruction per handshake and classifies its format (R/I/S/B/U/J).
- Extracts the immediate and sign-extends it to XLEN bits.
- Presents the result one cycle later behind a valid/ready handshake, with a skid register so backpressure loses nothing. Sits between fetch buffer and register-read.

---
 rtl/imm_gen_pipe.sv | 159 +++++++++++++++
 tb/tb_imm_gen_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: decodes format and immediate, then presents the
// result through an output register backed by a skid register.
module imm_gen_pipe #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned SHAMT_W = (XLEN == 64) ? 6 : 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    localparam logic [2:0] FmtR    = 3'd0;
    localparam logic [2:0] FmtI    = 3'd1;
    localparam logic [2:0] FmtS    = 3'd2;
    localparam logic [2:0] FmtB    = 3'd3;
    localparam logic [2:0] FmtU    = 3'd4;
    localparam logic [2:0] FmtJ    = 3'd5;
    localparam logic [2:0] FmtNone = 3'd7;

    function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_ill;

    assign opcode   = in_inst[6:0];
    assign funct3   = in_inst[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        dec_imm = '0;
        dec_fmt = FmtNone;
        dec_ill = 1'b0;
        case (opcode)
            7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                dec_fmt = FmtI;
                if (opcode == 7'b0010011 && is_shift) begin
                    dec_imm = XLEN'(in_inst[20 +: SHAMT_W]);
                end else if (opcode == 7'b0011011 && is_shift) begin
                    // Word shifts always carry a 5-bit shamt.
                    dec_imm = XLEN'(in_inst[24:20]);
                end else begin
                    dec_imm = sext({{20{in_inst[31]}}, in_inst[31:20]});
                end
            end
            7'b0100011: begin
                dec_fmt = FmtS;
                dec_imm = sext({{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]});
            end
            7'b1100011: begin
                dec_fmt = FmtB;
                dec_imm = sext({{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                                in_inst[11:8], 1'b0});
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FmtU;
                dec_imm = sext({in_inst[31:12], 12'b0});
            end
            7'b1101111: begin
                dec_fmt = FmtJ;
                dec_imm = sext({{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                                in_inst[30:21], 1'b0});
            end
            7'b0110011, 7'b0111011: begin
                dec_fmt = FmtR;
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
    end

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_imm_q, out_imm_d;
    logic [2:0]      out_fmt_q, out_fmt_d;
    logic            out_ill_q, out_ill_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_imm_q, skid_imm_d;
    logic [2:0]      skid_fmt_q, skid_fmt_d;
    logic            skid_ill_q, skid_ill_d;
    logic            in_xfer, out_load;

    assign in_ready    = !skid_valid_q;
    assign in_xfer     = in_valid && in_ready;
    // Output reg may take new data when empty or being consumed this cycle.
    assign out_load    = !out_valid_q || out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_fmt_d    = out_fmt_q;
        out_ill_d    = out_ill_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_fmt_d   = skid_fmt_q;
        skid_ill_d   = skid_ill_q;
        if (out_load) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_fmt_d    = skid_fmt_q;
                out_ill_d    = skid_ill_q;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                out_valid_d = 1'b1;
                out_imm_d   = dec_imm;
                out_fmt_d   = dec_fmt;
                out_ill_d   = dec_ill;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = dec_imm;
            skid_fmt_d   = dec_fmt;
            skid_ill_d   = dec_ill;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_fmt_q    <= FmtNone;
            out_ill_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_fmt_q   <= FmtNone;
            skid_ill_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_fmt_q    <= out_fmt_d;
            out_ill_q    <= out_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_fmt_q   <= skid_fmt_d;
            skid_ill_q   <= skid_ill_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_imm     = out_imm_q;
    assign out_fmt     = out_fmt_q;
    assign out_illegal = out_ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=64 and XLEN=32 instances share stimulus and are checked
// every cycle against a queue-based model plus hand-computed vectors.
module tb_imm_gen_pipe;

    logic        clk, rst_n, in_valid, out_ready;
    logic [31:0] in_inst;
    logic        in_ready, out_valid, out_ill;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic        in_ready32, out_valid32, out_ill32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;

    imm_gen_pipe #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
        .out_illegal(out_ill)
    );

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst),
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
        .out_fmt(out_fmt32), .out_illegal(out_ill32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic [63:0] imm64;
        logic [31:0] imm32;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    // Reference decode from the ISA field definitions using plain integer arithmetic.
    function automatic exp_t model(input logic [31:0] inst);
        exp_t e;
        longint v64, v32;
        logic [6:0] opc;
        logic [2:0] f3;
        opc = inst[6:0];
        f3 = inst[14:12];
        e.fmt = 3'd7;
        e.ill = 1'b0;
        v64 = 0;
        v32 = 0;
        if (opc inside {7'h13, 7'h1B, 7'h03, 7'h67, 7'h73}) begin
            e.fmt = 3'd1;
            if ((opc == 7'h13 || opc == 7'h1B) && (f3 == 3'd1 || f3 == 3'd5)) begin
                v64 = (opc == 7'h13) ? longint'((inst >> 20) % 64) : longint'((inst >> 20) % 32);
                v32 = longint'((inst >> 20) % 32);
            end else begin
                v64 = longint'(inst[31:20]);
                if (v64 >= 2048) v64 -= 4096;
                v32 = v64;
            end
        end else if (opc == 7'h23) begin
            e.fmt = 3'd2;
            v64 = longint'({inst[31:25], inst[11:7]});
            if (v64 >= 2048) v64 -= 4096;
            v32 = v64;
        end else if (opc == 7'h63) begin
            e.fmt = 3'd3;
            v64 = longint'({inst[31], inst[7], inst[30:25], inst[11:8]}) * 2;
            if (v64 >= 4096) v64 -= 8192;
            v32 = v64;
        end else if (opc == 7'h37 || opc == 7'h17) begin
            e.fmt = 3'd4;
            v64 = longint'(inst[31:12]) * 4096;
            if (inst[31]) v64 -= (longint'(1) << 32);
            v32 = v64;
        end else if (opc == 7'h6F) begin
            e.fmt = 3'd5;
            v64 = longint'({inst[31], inst[19:12], inst[20], inst[30:21]}) * 2;
            if (v64 >= (longint'(1) << 20)) v64 -= (longint'(1) << 21);
            v32 = v64;
        end else if (opc == 7'h33 || opc == 7'h3B) begin
            e.fmt = 3'd0;
        end else begin
            e.ill = 1'b1;
        end
        e.imm64 = 64'(v64);
        e.imm32 = v32[31:0];
        return e;
    endfunction

    exp_t q[$];
    logic [63:0] pops[$];
    bit m_pop, m_push;

    always @(negedge rst_n) q.delete();

    always @(posedge clk) begin
        if (rst_n) begin
            m_pop = (q.size() > 0) && out_ready;
            m_push = in_valid && (q.size() < 2);
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back(model(in_inst));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, q.size() < 2);
            chk("in_ready32", in_ready32, q.size() < 2);
            chk("out_valid", out_valid, q.size() > 0);
            chk("out_valid32", out_valid32, q.size() > 0);
            if (q.size() > 0) begin
                chk("imm64", out_imm, q[0].imm64);
                chk("imm32", 64'(out_imm32), 64'(q[0].imm32));
                chk("fmt", 64'(out_fmt), 64'(q[0].fmt));
                chk("fmt32", 64'(out_fmt32), 64'(q[0].fmt));
                chk("illegal", 64'(out_ill), 64'(q[0].ill));
            end
            if (out_valid && out_ready) pops.push_back(out_imm);
        end
    end

    // Present inst until accepted; called and returns at posedge+1.
    task automatic push(input logic [31:0] inst);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_inst = inst;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) chk("push_timeout", 64'(done), 64'd1);
    endtask

    logic [31:0] t_inst [10] = '{32'hFFF00093, 32'hFE21BC23, 32'hFE000EE3, 32'h800002B7,
                                 32'h001000EF, 32'h43F0D093, 32'h01F09093, 32'h0000007F,
                                 32'h00B50533, 32'h03F0909B};
    logic [63:0] t_imm64 [10] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF8,
                                  64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_8000_0000,
                                  64'h800, 64'h3F, 64'h1F, 64'h0, 64'h0, 64'h1F};
    logic [31:0] t_imm32 [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h8000_0000,
                                  32'h800, 32'h1F, 32'h1F, 32'h0, 32'h0, 32'h1F};
    logic [2:0]  t_fmt [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd1, 3'd7, 3'd0, 3'd1};
    logic        t_ill [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    logic [63:0] bp_exp [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF8,
                                64'hFFFF_FFFF_8000_0000};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        exp_t m;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_inst = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_fmt", 64'(out_fmt), 64'd7);
        chk("rst_imm", out_imm, 64'd0);
        chk("rst_illegal", 64'(out_ill), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, one at a time with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            m = model(t_inst[i]);
            chk("model_pin", m.imm64, t_imm64[i]);
            push(t_inst[i]);
            @(negedge clk);
            chk("vec_valid", 64'(out_valid), 64'd1);
            chk("vec_imm64", out_imm, t_imm64[i]);
            chk("vec_imm32", 64'(out_imm32), 64'(t_imm32[i]));
            chk("vec_fmt", 64'(out_fmt), 64'(t_fmt[i]));
            chk("vec_illegal", 64'(out_ill), 64'(t_ill[i]));
            @(posedge clk);
            #1;
        end

        // Backpressure: three back-to-back, consumer stalled for four cycles.
        out_ready = 1'b0;
        pops.delete();
        fork
            begin
                push(t_inst[0]);
                push(t_inst[1]);
                push(t_inst[3]);
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready_low", 64'(in_ready), 64'd0);
                chk("bp_out_valid", 64'(out_valid), 64'd1);
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        chk("bp_count", 64'(pops.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            chk("bp_order", (i < pops.size()) ? pops[i] : 64'hDEAD, bp_exp[i]);

        // Streaming with an irregular consumer to exercise simultaneous transfers.
        fork
            begin
                for (int i = 0; i < 10; i++) push(t_inst[(i * 3) % 10]);
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    @(posedge clk);
                    #1 out_ready = (k % 3) != 0;
                end
            end
        join
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Async reset with both registers full.
        out_ready = 1'b0;
        push(t_inst[2]);
        push(t_inst[4]);
        #3;
        chk("pre_rst_in_ready", 64'(in_ready), 64'd0);
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_fmt", 64'(out_fmt), 64'd7);
        chk("arst_imm", out_imm, 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push(t_inst[8]);
        @(negedge clk);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_fmt", 64'(out_fmt), 64'd0);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
